// File: rtl/dti_imem_prefetch.sv
// Instruction prefetch buffer between the core fetch port and instruction memory.
// Streams sequential words into a small FIFO and refetches on a non-sequential address.
module dti_imem_prefetch #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    core_req,
    input  logic [ADDR_WIDTH-1:0]   core_address,
    output logic                    core_ack,
    output logic [DATA_WIDTH-1:0]   core_data,
    output logic                    imem_req,
    output logic [ADDR_WIDTH-1:0]   imem_address,
    input  logic                    imem_ack,
    input  logic [DATA_WIDTH-1:0]   imem_data_in,
    output logic [$clog2(DEPTH):0]  buf_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_DISCARD = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  fetch_addr_q, fetch_addr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   core_ack_q, core_ack_d;
    logic [DATA_WIDTH-1:0]  core_data_q, core_data_d;
    logic                   imem_req_q, imem_req_d;
    logic [ADDR_WIDTH-1:0]  imem_address_q, imem_address_d;

    logic [ADDR_WIDTH-1:0]  fifo_addr_q [DEPTH];
    logic [DATA_WIDTH-1:0]  fifo_data_q [DEPTH];

    logic fifo_empty;
    logic hit;
    logic redirect;
    logic push;

    // Core-side decode; the request is ignored in the cycle core_ack is high.
    always_comb begin
        fifo_empty = (count_q == '0);
        hit        = 1'b0;
        redirect   = 1'b0;
        if (core_req && !core_ack_q) begin
            if (!fifo_empty && (fifo_addr_q[rd_ptr_q] == core_address)) begin
                hit = 1'b1;
            end else if (!(fifo_empty && (core_address == fetch_addr_q))) begin
                redirect = 1'b1;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        fetch_addr_d   = fetch_addr_q;
        rd_ptr_d       = rd_ptr_q;
        wr_ptr_d       = wr_ptr_q;
        count_d        = count_q;
        core_ack_d     = 1'b0;
        core_data_d    = core_data_q;
        imem_req_d     = imem_req_q;
        imem_address_d = imem_address_q;
        push           = 1'b0;

        if (hit) begin
            core_ack_d  = 1'b1;
            core_data_d = fifo_data_q[rd_ptr_q];
        end

        unique case (state_q)
            S_IDLE: begin
                // A redirect in IDLE goes straight out to memory with the new address.
                if (redirect) begin
                    imem_req_d     = 1'b1;
                    imem_address_d = core_address;
                    state_d        = S_REQ;
                end else if (count_q < CNT_W'(DEPTH)) begin
                    imem_req_d     = 1'b1;
                    imem_address_d = fetch_addr_q;
                    state_d        = S_REQ;
                end
            end
            S_REQ: begin
                if (imem_ack) begin
                    imem_req_d = 1'b0;
                    state_d    = S_IDLE;
                    if (!redirect) begin
                        push         = 1'b1;
                        fetch_addr_d = imem_address_q + ADDR_WIDTH'(4);
                    end
                end else if (redirect) begin
                    state_d = S_DISCARD;
                end
            end
            S_DISCARD: begin
                if (imem_ack) begin
                    imem_req_d = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            default: begin
                imem_req_d = 1'b0;
                state_d    = S_IDLE;
            end
        endcase

        if (redirect) begin
            fetch_addr_d = core_address;
            rd_ptr_d     = '0;
            wr_ptr_d     = '0;
            count_d      = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (hit) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push && !hit) begin
                count_d = count_q + CNT_W'(1);
            end else if (!push && hit) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            fetch_addr_q   <= '0;
            rd_ptr_q       <= '0;
            wr_ptr_q       <= '0;
            count_q        <= '0;
            core_ack_q     <= 1'b0;
            core_data_q    <= '0;
            imem_req_q     <= 1'b0;
            imem_address_q <= '0;
        end else begin
            state_q        <= state_d;
            fetch_addr_q   <= fetch_addr_d;
            rd_ptr_q       <= rd_ptr_d;
            wr_ptr_q       <= wr_ptr_d;
            count_q        <= count_d;
            core_ack_q     <= core_ack_d;
            core_data_q    <= core_data_d;
            imem_req_q     <= imem_req_d;
            imem_address_q <= imem_address_d;
        end
    end

    // Entry storage needs no reset; validity is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= imem_address_q;
            fifo_data_q[wr_ptr_q] <= imem_data_in;
        end
    end

    assign core_ack     = core_ack_q;
    assign core_data    = core_data_q;
    assign imem_req     = imem_req_q;
    assign imem_address = imem_address_q;
    assign buf_count    = count_q;

endmodule

// File: tb/tb_dti_imem_prefetch.sv
// Scoreboard bench for dti_imem_prefetch: directed fetch sequences against a latency-programmable
// memory model; a negedge monitor pops expected instruction words on every core_ack.
module tb_dti_imem_prefetch;

    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          core_req;
    logic [AW-1:0] core_address;
    logic          core_ack;
    logic [DW-1:0] core_data;
    logic          imem_req;
    logic [AW-1:0] imem_address;
    logic          imem_ack;
    logic [DW-1:0] imem_data_in;
    logic [2:0]    buf_count;

    dti_imem_prefetch #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .core_req     (core_req),
        .core_address (core_address),
        .core_ack     (core_ack),
        .core_data    (core_data),
        .imem_req     (imem_req),
        .imem_address (imem_address),
        .imem_ack     (imem_ack),
        .imem_data_in (imem_data_in),
        .buf_count    (buf_count)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int            n_vec  = 0;
    int            n_fail = 0;
    logic [DW-1:0] exp_q[$];
    logic [AW-1:0] req_log[$];
    int unsigned   req_cyc[$];
    int            mem_lat    = 1;
    bit            inject_ack = 1'b0;
    int            wcnt       = 0;

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return {a[15:0], a[31:16]} ^ 32'hA5A5_5A5A;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_vec++;
        n_fail++;
        $display("FAIL %s: condition not reached within 300 cycles", name);
    endtask

    // Memory model: ack mem_lat cycles into each request, with data derived from the address.
    initial begin
        imem_ack     = 1'b0;
        imem_data_in = '0;
        forever begin
            @(posedge clk);
            #1;
            imem_ack = 1'b0;
            if (inject_ack) begin
                inject_ack   = 1'b0;
                imem_ack     = 1'b1;
                imem_data_in = 32'hDEAD_BEEF;
                wcnt         = 0;
            end else if (reset || !imem_req) begin
                wcnt = 0;
            end else begin
                wcnt++;
                if (wcnt >= mem_lat) begin
                    imem_ack     = 1'b1;
                    imem_data_in = mem_word(imem_address);
                    wcnt         = 0;
                end
            end
        end
    end

    // Core-side monitor: every core_ack pops one expected word.
    initial begin
        logic          prev_ack;
        logic [DW-1:0] e;
        prev_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset && core_ack) begin
                if (prev_ack) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL core_ack_pulse: got ack in two consecutive cycles, expected a 1-cycle pulse");
                end
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL unexpected_ack: got data 0x%0h, expected no ack", core_data);
                end else begin
                    e = exp_q.pop_front();
                    check("core_data", core_data, e);
                end
            end
            prev_ack = reset ? 1'b0 : core_ack;
        end
    end

    // Memory-side monitor: logs requests, checks handshake stability and the idle gap.
    initial begin
        logic          pr;
        logic          pack;
        logic [AW-1:0] paddr;
        pr    = 1'b0;
        pack  = 1'b0;
        paddr = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                pr   = 1'b0;
                pack = 1'b0;
            end else begin
                if (imem_req && !pr) begin
                    req_log.push_back(imem_address);
                    req_cyc.push_back(cyc);
                end
                if (imem_req && pack) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL req_gap: got imem_req=1 in cycle after imem_ack, expected 0");
                end
                if (imem_req && pr && !pack) check("imem_addr_stable", imem_address, paddr);
                pr    = imem_req;
                paddr = imem_address;
                pack  = imem_ack && imem_req;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_fetch(input logic [AW-1:0] a);
        core_req     = 1'b1;
        core_address = a;
        exp_q.push_back(mem_word(a));
    endtask

    task automatic wait_ack(input string name, input int exp_lat);
        int n;
        bit got;
        n   = 0;
        got = 1'b0;
        for (int i = 1; i <= 300; i++) begin
            tick();
            if (core_ack) begin
                n   = i;
                got = 1'b1;
                break;
            end
        end
        core_req = 1'b0;
        if (!got) timeout_fail(name);
        else if (exp_lat > 0) check({name, "_lat"}, n, exp_lat);
    endtask

    task automatic wait_state(input string name, input int cnt, input logic req);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if ((32'(buf_count) == cnt) && (imem_req == req)) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) timeout_fail(name);
    endtask

    task automatic wait_req_addr(input string name, input logic [AW-1:0] a);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (imem_req && (imem_address == a)) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) timeout_fail(name);
    endtask

    task automatic wait_log(input string name, input int n);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (req_log.size() >= n) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) timeout_fail(name);
    endtask

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation still running at 200000 time units, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        int          lg;
        int unsigned n0;
        reset        = 1'b1;
        core_req     = 1'b0;
        core_address = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_core_ack", 32'(core_ack), 0);
        check("rst_core_data", core_data, 0);
        check("rst_imem_req", 32'(imem_req), 0);
        check("rst_imem_address", imem_address, 0);
        check("rst_buf_count", 32'(buf_count), 0);
        reset = 1'b0;

        // Cold start from 0x0: sequential prefetch, saturation at DEPTH entries.
        mem_lat = 1;
        start_fetch(32'h0);
        wait_ack("t1_first", 0);
        wait_state("t1_full", 4, 1'b0);
        repeat (4) tick();
        check("t1_buf_count_sat", 32'(buf_count), 4);
        check("t1_no_req_when_full", 32'(imem_req), 0);
        check("t1_req_total", req_log.size(), 5);
        for (int i = 0; i < 5; i++) check("t1_req_addr", req_log[i], 32'(i * 4));
        start_fetch(32'h4);
        wait_ack("t1_hit", 1);
        wait_log("t1_refill", 6);
        check("t1_refill_addr", req_log[5], 32'h14);

        // Straight-line hits back to back.
        start_fetch(32'hFC);
        wait_ack("t2_redirect", 0);
        wait_state("t2_full", 4, 1'b0);
        start_fetch(32'h100);
        wait_ack("t2_a", 1);
        start_fetch(32'h104);
        wait_ack("t2_b", 2);
        start_fetch(32'h108);
        wait_ack("t2_c", 2);

        // Branch out of a full FIFO.
        start_fetch(32'h1C);
        wait_ack("t3_pre", 0);
        wait_state("t3_full", 4, 1'b0);
        n0 = cyc;
        lg = req_log.size();
        start_fetch(32'h80);
        tick();
        check("t3_flush_count", 32'(buf_count), 0);
        check("t3_imem_req", 32'(imem_req), 1);
        check("t3_imem_address", imem_address, 32'h80);
        wait_ack("t3_branch", 0);
        check("t3_log_addr", req_log[lg], 32'h80);
        check("t3_req_cycle", req_cyc[lg], n0 + 1);

        // Redirect while a slow request is outstanding.
        mem_lat = 5;
        start_fetch(32'h0C);
        wait_ack("t4_pre", 0);
        wait_req_addr("t4_pending", 32'h10);
        start_fetch(32'h200);
        tick();
        lg = req_log.size();
        check("t4_req_held", 32'(imem_req), 1);
        check("t4_addr_held", imem_address, 32'h10);
        wait_ack("t4_redirect", 0);
        check("t4_next_req", req_log[lg], 32'h200);

        // Address wrap at the top of the address space.
        wait_state("t5_idle", 4, 1'b0);
        mem_lat = 1;
        lg = req_log.size();
        start_fetch(32'hFFFF_FFFC);
        wait_ack("t5_top", 0);
        start_fetch(32'h0);
        wait_ack("t5_zero", 0);
        wait_log("t5_log", lg + 3);
        check("t5_req_top", req_log[lg], 32'hFFFF_FFFC);
        check("t5_req_wrap", req_log[lg+1], 32'h0);
        check("t5_req_seq", req_log[lg+2], 32'h4);

        // Asynchronous reset mid-transfer, then a stray ack.
        mem_lat = 4;
        start_fetch(32'h300);
        wait_ack("t6_pre", 0);
        wait_state("t6_setup", 2, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check("t6_async_imem_req", 32'(imem_req), 0);
        check("t6_async_buf_count", 32'(buf_count), 0);
        check("t6_async_core_ack", 32'(core_ack), 0);
        repeat (2) @(posedge clk);
        @(posedge clk);
        inject_ack = 1'b1;
        #1;
        reset = 1'b0;
        lg    = req_log.size();
        tick();
        check("t6_late_ack_count", 32'(buf_count), 0);
        check("t6_restart_req", 32'(imem_req), 1);
        check("t6_restart_addr", imem_address, 32'h0);
        start_fetch(32'h0);
        wait_ack("t6_restart", 0);
        check("t6_log_addr", req_log[lg], 32'h0);

        repeat (5) tick();
        check("scoreboard_drain", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
